// File: rtl/jimbo_bus_responder.sv
// Memory-side responder for the Jimbo nibble bus: RAM, GPIO, a TX FIFO with a
// valid/ready port and a 16-bit timer with a snapshot shadow for coherent reads.
module jimbo_bus_responder #(
   parameter int RAM_DEPTH  = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic [3:0]  cpu_wdata,
   output logic [3:0]  cpu_rdata,
   output logic [3:0]  gpio_out,
   input  logic [3:0]  gpio_in,
   output logic [3:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam logic [11:0] RAM_LIMIT  = 12'(RAM_DEPTH);
   localparam logic [PW:0] FIFO_LIMIT = (PW + 1)'(FIFO_DEPTH);

   localparam logic [10:0] ADDR_GPIO_OUT = 11'h7F0;
   localparam logic [10:0] ADDR_GPIO_IN  = 11'h7F1;
   localparam logic [10:0] ADDR_TX_PUSH  = 11'h7F2;
   localparam logic [10:0] ADDR_STATUS   = 11'h7F3;
   localparam logic [10:0] ADDR_TIMER0   = 11'h7F4;
   localparam logic [10:0] ADDR_TIMER1   = 11'h7F5;
   localparam logic [10:0] ADDR_TIMER2   = 11'h7F6;
   localparam logic [10:0] ADDR_TIMER3   = 11'h7F7;

   logic [3:0]        ram      [RAM_DEPTH];
   logic [3:0]        fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       fifo_count;
   logic              ovf;
   logic [15:0]       timer;
   logic [11:0]       shadow;
   logic [3:0]        sync_1;
   logic [3:0]        sync_2;
   logic              push_wr_prev;

   logic              is_write;
   logic              ram_hit;
   logic [RAM_AW-1:0] ram_idx;
   logic              push_sel;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [3:0]        read_value;

   assign is_write   = cpu_rw;
   assign ram_hit    = ({1'b0, cpu_addr} < RAM_LIMIT);
   assign ram_idx    = cpu_addr[RAM_AW-1:0];
   assign fifo_full  = (fifo_count == FIFO_LIMIT);
   assign fifo_empty = (fifo_count == '0);
   assign tx_valid   = !fifo_empty;
   assign tx_data    = fifo_empty ? 4'h0 : fifo_mem[rd_ptr];
   assign pop        = tx_valid && tx_ready;

   // A held write to the push address pushes only on its first cycle.
   assign push_sel = is_write && (cpu_addr == ADDR_TX_PUSH);
   assign push_req = push_sel && !push_wr_prev;
   assign push_ok  = push_req && (!fifo_full || pop);

   always_comb begin
      read_value = 4'h0;
      if (ram_hit) begin
         read_value = ram[ram_idx];
      end else begin
         case (cpu_addr)
            ADDR_GPIO_OUT: read_value = gpio_out;
            ADDR_GPIO_IN:  read_value = sync_2;
            ADDR_STATUS:   read_value = {1'b0, ovf, fifo_empty, fifo_full};
            ADDR_TIMER0:   read_value = timer[3:0];
            ADDR_TIMER1:   read_value = shadow[3:0];
            ADDR_TIMER2:   read_value = shadow[7:4];
            ADDR_TIMER3:   read_value = shadow[11:8];
            default:       read_value = 4'h0;
         endcase
      end
   end

   // Storage arrays carry no reset; reset only blocks writes in its cycle.
   always_ff @(posedge clk) begin
      if (rst_n && is_write && ram_hit) begin
         ram[ram_idx] <= cpu_wdata;
      end
      if (rst_n && push_ok) begin
         fifo_mem[wr_ptr] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cpu_rdata    <= 4'h0;
         gpio_out     <= 4'h0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         ovf          <= 1'b0;
         timer        <= 16'h0000;
         shadow       <= 12'h000;
         sync_1       <= 4'h0;
         sync_2       <= 4'h0;
         push_wr_prev <= 1'b0;
      end else begin
         cpu_rdata    <= is_write ? 4'h0 : read_value;
         timer        <= timer + 16'd1;
         sync_1       <= gpio_in;
         sync_2       <= sync_1;
         push_wr_prev <= push_sel;

         if (is_write && (cpu_addr == ADDR_GPIO_OUT)) begin
            gpio_out <= cpu_wdata;
         end
         if (!is_write && (cpu_addr == ADDR_TIMER0)) begin
            shadow <= timer[15:4];
         end

         if (push_req && fifo_full && !pop) begin
            ovf <= 1'b1;
         end else if (is_write && (cpu_addr == ADDR_STATUS) && cpu_wdata[2]) begin
            ovf <= 1'b0;
         end

         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_jimbo_bus_responder.sv
// Directed bench for jimbo_bus_responder: one bus cycle per applyStimulus call,
// outputs checked #1 after the edge against hand-computed values.
module tb_jimbo_bus_responder;

   logic        clk;
   logic        rst_n;
   logic [10:0] cpu_addr;
   logic        cpu_rw;
   logic [3:0]  cpu_wdata;
   logic [3:0]  cpu_rdata;
   logic [3:0]  gpio_out;
   logic [3:0]  gpio_in;
   logic [3:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int total;
   int bad;

   jimbo_bus_responder #(.RAM_DEPTH(256), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_rw    (cpu_rw),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .gpio_out  (gpio_out),
      .gpio_in   (gpio_in),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One bus cycle: drive, cross the rising edge, settle.
   task automatic applyStimulus(input logic [10:0] addr, input logic rw, input logic [3:0] wdata);
      cpu_addr  = addr;
      cpu_rw    = rw;
      cpu_wdata = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [3:0] drain_a [8];
      logic [3:0] drain_b [8];
      drain_a = '{4'h3, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      drain_b = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      gpio_in   = 4'h0;
      tx_ready  = 1'b0;
      cpu_addr  = 11'h000;
      cpu_rw    = 1'b0;
      cpu_wdata = 4'h0;

      $display("[TB] reset and status");
      applyStimulus(11'h7FF, 1'b0, 4'h0);
      applyStimulus(11'h7FF, 1'b0, 4'h0);
      checkOutput("reset_rdata", 16'(cpu_rdata), 16'h0);
      checkOutput("reset_gpio_out", 16'(gpio_out), 16'h0);
      checkOutput("reset_tx_valid", 16'(tx_valid), 16'h0);
      checkOutput("reset_tx_data", 16'(tx_data), 16'h0);
      rst_n = 1'b1;
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("reset_status", 16'(cpu_rdata), 16'h2);

      $display("[TB] RAM");
      applyStimulus(11'h000, 1'b1, 4'hA);
      checkOutput("write_returns_zero", 16'(cpu_rdata), 16'h0);
      applyStimulus(11'h0FF, 1'b1, 4'h5);
      applyStimulus(11'h000, 1'b0, 4'h0);
      checkOutput("ram_000", 16'(cpu_rdata), 16'hA);
      applyStimulus(11'h0FF, 1'b0, 4'h0);
      checkOutput("ram_0ff", 16'(cpu_rdata), 16'h5);
      applyStimulus(11'h100, 1'b1, 4'h7);
      applyStimulus(11'h100, 1'b0, 4'h0);
      checkOutput("ram_100_unmapped", 16'(cpu_rdata), 16'h0);
      applyStimulus(11'h000, 1'b0, 4'h0);
      checkOutput("ram_no_alias", 16'(cpu_rdata), 16'hA);

      $display("[TB] TX FIFO fill, overflow, drain");
      applyStimulus(11'h7F2, 1'b1, 4'h3);
      checkOutput("push_valid", 16'(tx_valid), 16'h1);
      applyStimulus(11'h7F2, 1'b1, 4'h3);
      applyStimulus(11'h7F2, 1'b1, 4'h3);
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("status_one_entry", 16'(cpu_rdata), 16'h0);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(11'h7F2, 1'b1, drain_a[i]);
         applyStimulus(11'h7F2, 1'b0, 4'h0);
         checkOutput("push_addr_reads_zero", 16'(cpu_rdata), 16'h0);
      end
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("status_full", 16'(cpu_rdata), 16'h1);
      applyStimulus(11'h7F2, 1'b1, 4'hF);
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("status_ovf_full", 16'(cpu_rdata), 16'h5);
      checkOutput("head_after_drop", 16'(tx_data), 16'h3);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("drain_a_valid", 16'(tx_valid), 16'h1);
         checkOutput("drain_a_data", 16'(tx_data), 16'(drain_a[i]));
         applyStimulus(11'h7FF, 1'b0, 4'h0);
      end
      checkOutput("drain_a_empty", 16'(tx_valid), 16'h0);
      checkOutput("drain_a_data_zero", 16'(tx_data), 16'h0);
      tx_ready = 1'b0;
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("status_ovf_empty", 16'(cpu_rdata), 16'h6);
      applyStimulus(11'h7F3, 1'b1, 4'h4);
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("status_ovf_cleared", 16'(cpu_rdata), 16'h2);

      $display("[TB] full push with simultaneous pop");
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(11'h7F2, 1'b1, 4'(i));
         applyStimulus(11'h7F3, 1'b0, 4'h0);
      end
      checkOutput("refill_full", 16'(cpu_rdata), 16'h1);
      tx_ready = 1'b1;
      checkOutput("head_before_pushpop", 16'(tx_data), 16'h1);
      applyStimulus(11'h7F2, 1'b1, 4'h9);
      tx_ready = 1'b0;
      applyStimulus(11'h7F3, 1'b0, 4'h0);
      checkOutput("pushpop_full_no_ovf", 16'(cpu_rdata), 16'h1);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("drain_b_data", 16'(tx_data), 16'(drain_b[i]));
         applyStimulus(11'h7FF, 1'b0, 4'h0);
      end
      checkOutput("drain_b_empty", 16'(tx_valid), 16'h0);
      tx_ready = 1'b0;

      $display("[TB] GPIO");
      applyStimulus(11'h7F0, 1'b1, 4'hC);
      checkOutput("gpio_out_written", 16'(gpio_out), 16'hC);
      applyStimulus(11'h7F0, 1'b0, 4'h0);
      checkOutput("gpio_out_readback", 16'(cpu_rdata), 16'hC);
      gpio_in = 4'h6;
      applyStimulus(11'h7FF, 1'b0, 4'h0);
      applyStimulus(11'h7F1, 1'b0, 4'h0);
      checkOutput("gpio_in_not_yet", 16'(cpu_rdata), 16'h0);
      applyStimulus(11'h7F1, 1'b0, 4'h0);
      checkOutput("gpio_in_synced", 16'(cpu_rdata), 16'h6);

      $display("[TB] reset during drain");
      applyStimulus(11'h7F2, 1'b1, 4'hD);
      applyStimulus(11'h7FF, 1'b0, 4'h0);
      applyStimulus(11'h7F2, 1'b1, 4'hE);
      applyStimulus(11'h7FF, 1'b0, 4'h0);
      tx_ready = 1'b1;
      applyStimulus(11'h7F0, 1'b0, 4'h0);
      checkOutput("mid_drain_valid", 16'(tx_valid), 16'h1);
      checkOutput("mid_drain_head", 16'(tx_data), 16'hE);
      rst_n = 1'b0;
      applyStimulus(11'h7F0, 1'b1, 4'h3);
      checkOutput("rst_gpio_out", 16'(gpio_out), 16'h0);
      checkOutput("rst_tx_valid", 16'(tx_valid), 16'h0);
      checkOutput("rst_tx_data", 16'(tx_data), 16'h0);
      checkOutput("rst_rdata", 16'(cpu_rdata), 16'h0);
      tx_ready = 1'b0;

      $display("[TB] timer snapshot");
      applyStimulus(11'h7FF, 1'b0, 4'h0);
      rst_n = 1'b1;
      applyStimulus(11'h7F4, 1'b0, 4'h0);
      checkOutput("timer_first_edge", 16'(cpu_rdata), 16'h0);
      for (int i = 0; i < 254; i++) begin
         applyStimulus(11'h7FF, 1'b0, 4'h0);
      end
      applyStimulus(11'h7F4, 1'b0, 4'h0);
      checkOutput("timer_nib0", 16'(cpu_rdata), 16'hF);
      applyStimulus(11'h7F5, 1'b0, 4'h0);
      checkOutput("timer_nib1", 16'(cpu_rdata), 16'hF);
      applyStimulus(11'h7F6, 1'b0, 4'h0);
      checkOutput("timer_nib2", 16'(cpu_rdata), 16'h0);
      applyStimulus(11'h7F7, 1'b0, 4'h0);
      checkOutput("timer_nib3", 16'(cpu_rdata), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
